// File: rtl/formation_pkg.sv
// formation_pkg: shared state type, coordinate width and LFSR constants for the enemy formation
package formation_pkg;
  typedef enum logic [1:0] {RUN, CLEARED, INVADED} state_t;
  localparam int COORD_W = 11;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/formation_extent.sv
// formation_extent: combinational occupancy summary (column span, bottom row, per-column shooters) of the alive mask
module formation_extent #(
  parameter int ROWS = 3,
  parameter int COLS = 8,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic [ROWS*COLS-1:0]    alive,
  output logic [CW-1:0]           lc,
  output logic [CW-1:0]           rc,
  output logic [RW-1:0]           br,
  output logic [COLS-1:0]         col_any,
  output logic [COLS-1:0][RW-1:0] col_low
);
  always_comb begin
    lc = '0;
    rc = '0;
    br = '0;
    col_any = '0;
    col_low = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive[r*COLS+c]) begin
          col_any[c] = 1'b1;
          col_low[c] = RW'(r);
          br = RW'(r);
        end
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lc = CW'(c);
    for (int c = 0; c < COLS; c++) if (col_any[c]) rc = CW'(c);
  end
endmodule

// File: rtl/formation_ctrl.sv
// formation_ctrl: enemy grid owner -- march/drop/bounce, kill accounting, speed-up and shooter selection
module formation_ctrl #(
  parameter int ROWS        = 3,
  parameter int COLS        = 8,
  parameter int COORD_W     = formation_pkg::COORD_W,
  parameter int X0          = 150,
  parameter int Y0          = 40,
  parameter int DX          = 60,
  parameter int DY          = 50,
  parameter int STEP_X      = 20,
  parameter int SPRITE_W    = 40,
  parameter int SPRITE_H    = 30,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_LIMIT     = 420,
  parameter int BASE_PERIOD = 2000000,
  parameter int MIN_PERIOD  = 250000,
  parameter int SPEEDUP     = 70000,
  parameter int FIRE_PERIOD = 30000000,
  localparam int N  = ROWS * COLS,
  localparam int IW = $clog2(N),
  localparam int AW = $clog2(N + 1),
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               kill_valid,
  input  logic [IW-1:0]      kill_idx,
  output logic [COORD_W-1:0] origin_x,
  output logic [COORD_W-1:0] origin_y,
  output logic [N-1:0]       alive,
  output logic [AW-1:0]      alive_count,
  output logic               step_pulse,
  output logic               wave_clear,
  output logic               invaded,
  output logic               fire_valid,
  output logic [COORD_W-1:0] fire_x,
  output logic [COORD_W-1:0] fire_y,
  input  logic               fire_ready
);
  import formation_pkg::*;
  state_t state, state_nx;
  logic dir_r;
  logic [31:0] step_cnt, fire_cnt, period, dead;
  logic [15:0] lfsr, lfsr_nx;
  logic searching, kill, step_due, fire_due, drop, hit;
  logic [CW-1:0] scol, scount, lc, rc;
  logic [RW-1:0] br;
  logic [COLS-1:0] col_any;
  logic [COLS-1:0][RW-1:0] col_low;
  logic signed [31:0] far_r, far_l, bottom;
  logic [COORD_W-1:0] ox_nx, oy_nx;
  formation_extent #(.ROWS(ROWS), .COLS(COLS)) u_extent (
    .alive(alive), .lc(lc), .rc(rc), .br(br), .col_any(col_any), .col_low(col_low)
  );
  assign lfsr_nx = lfsr_next(lfsr);
  assign kill = kill_valid && 32'(kill_idx) < N && alive[kill_idx];
  assign hit = col_any[scol];
  assign wave_clear = state == RUN && alive_count == '0;
  assign invaded = state == INVADED;
  always_comb begin
    dead = 32'(N) - 32'(alive_count);
    period = (dead * SPEEDUP + MIN_PERIOD >= BASE_PERIOD) ? MIN_PERIOD : BASE_PERIOD - dead * SPEEDUP;
    step_due = state == RUN && enable && alive_count != '0 && step_cnt >= period - 1;
    fire_due = state == RUN && enable && !fire_valid && !searching && fire_cnt >= FIRE_PERIOD - 1;
    // signed reach so a left step past zero compares negative instead of wrapping
    far_r = 32'(origin_x) + 32'(rc) * DX + SPRITE_W + STEP_X;
    far_l = 32'(origin_x) + 32'(lc) * DX - STEP_X;
    drop = dir_r ? far_r > X_MAX : far_l < X_MIN;
    ox_nx = drop ? origin_x : dir_r ? origin_x + COORD_W'(STEP_X) : origin_x - COORD_W'(STEP_X);
    oy_nx = drop ? origin_y + COORD_W'(DY) : origin_y;
    bottom = 32'(oy_nx) + 32'(br) * DY + SPRITE_H;
    state_nx = state;
    if (state == CLEARED) state_nx = RUN;
    else if (state == RUN) state_nx = alive_count == '0 ? CLEARED : (step_due && bottom >= Y_LIMIT) ? INVADED : RUN;
  end
  always_ff @(posedge clk) state <= reset ? RUN : state_nx;
  always_ff @(posedge clk) begin
    step_pulse <= 1'b0;
    if (reset || state == CLEARED) begin
      origin_x <= COORD_W'(X0);
      origin_y <= COORD_W'(Y0);
      alive <= '1;
      alive_count <= AW'(N);
      dir_r <= 1'b1;
      step_cnt <= '0;
      fire_cnt <= '0;
      lfsr <= LFSR_SEED;
      searching <= 1'b0;
      scol <= '0;
      scount <= '0;
      fire_valid <= 1'b0;
      fire_x <= '0;
      fire_y <= '0;
    end else begin
      if (kill) begin
        alive[kill_idx] <= 1'b0;
        alive_count <= alive_count - AW'(1);
      end
      if (state == RUN && enable) step_cnt <= step_due ? '0 : step_cnt + 1;
      if (step_due) begin
        origin_x <= ox_nx;
        origin_y <= oy_nx;
        dir_r <= dir_r ^ drop;
        step_pulse <= 1'b1;
      end
      // the fire period is held at zero while a shot is being searched for or is pending
      if (state == RUN && enable) fire_cnt <= (fire_valid || searching || fire_due) ? '0 : fire_cnt + 1;
      if (fire_due) begin
        lfsr <= lfsr_nx;
        scol <= CW'(32'(lfsr_nx) % COLS);
        scount <= '0;
        searching <= 1'b1;
      end
      if (searching && state == RUN && enable) begin
        if (hit) begin
          fire_valid <= 1'b1;
          fire_x <= origin_x + COORD_W'(32'(scol) * DX + SPRITE_W / 2);
          fire_y <= origin_y + COORD_W'(32'(col_low[scol]) * DY + SPRITE_H);
          searching <= 1'b0;
        end else begin
          searching <= 32'(scount) != COLS - 1;
          scol <= 32'(scol) == COLS - 1 ? '0 : scol + CW'(1);
          scount <= scount + CW'(1);
        end
      end
      if (fire_valid && fire_ready) fire_valid <= 1'b0;
      if (state_nx != RUN) begin
        fire_valid <= 1'b0;
        searching <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_formation_ctrl.sv
// tb_formation_ctrl: random stimulus against a behavioural formation model with queued expected events
module tb_formation_ctrl;
  localparam int ROWS = 3, COLS = 8, N = 24, X0 = 150, Y0 = 40, DX = 60, DY = 50, STEP_X = 20;
  localparam int SW = 40, SH = 30, X_MAX = 639, Y_LIMIT = 420, BASE = 16, MINP = 4, SPD = 1, FIRE = 8;
  logic clk = 0, reset = 1, enable = 0, kill_valid = 0, fire_ready = 0;
  logic [4:0] kill_idx = '0;
  logic [10:0] origin_x, origin_y, fire_x, fire_y;
  logic [N-1:0] alive;
  logic [4:0] alive_count;
  logic step_pulse, wave_clear, invaded, fire_valid;
  int n_checks = 0, n_fail = 0;
  bit started = 0;
  int m_st, m_ox, m_oy, m_cnt, m_fcnt, m_lfsr, m_scol, m_sn;
  bit m_right, m_srch, m_fv;
  logic [N-1:0] m_alive;
  int step_q[$], fire_q[$], wave_q[$];
  always #5 clk = ~clk;
  formation_ctrl #(.BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .SPEEDUP(SPD), .FIRE_PERIOD(FIRE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .kill_valid(kill_valid), .kill_idx(kill_idx),
    .origin_x(origin_x), .origin_y(origin_y), .alive(alive), .alive_count(alive_count),
    .step_pulse(step_pulse), .wave_clear(wave_clear), .invaded(invaded),
    .fire_valid(fire_valid), .fire_x(fire_x), .fire_y(fire_y), .fire_ready(fire_ready)
  );
  function automatic void check(input string nm, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endfunction
  function automatic int lfsr_step(input int l);
    int fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 'hFFFF;
  endfunction
  function automatic bit col_has(input int c);
    for (int r = 0; r < ROWS; r++) if (m_alive[r*COLS+c]) return 1;
    return 0;
  endfunction
  function automatic int low_row(input int c);
    int b = 0;
    for (int r = 0; r < ROWS; r++) if (m_alive[r*COLS+c]) b = r;
    return b;
  endfunction
  task automatic model_reset();
    m_st = 0; m_ox = X0; m_oy = Y0; m_right = 1; m_alive = '1;
    m_cnt = 0; m_fcnt = 0; m_lfsr = 'hACE1; m_srch = 0; m_fv = 0; m_scol = 0; m_sn = 0;
  endtask
  task automatic model_tick();
    int ac, per, lc, rc, br, px, py;
    bit drp, pre_fv;
    if (reset) begin
      model_reset();
      step_q.delete(); fire_q.delete(); wave_q.delete();
      return;
    end
    if (m_st == 1) begin
      model_reset();
      return;
    end
    ac = $countones(m_alive); pre_fv = m_fv; px = m_ox; py = m_oy;
    if (m_st == 0) begin
      if (pre_fv && fire_ready) m_fv = 0;
      if (ac == 0) m_st = 1;
      else if (enable) begin
        per = BASE - (N - ac) * SPD;
        if (per < MINP) per = MINP;
        if (m_cnt >= per - 1) begin
          m_cnt = 0; lc = COLS; rc = -1; br = 0;
          for (int c = 0; c < COLS; c++) if (col_has(c)) begin
            if (lc == COLS) lc = c;
            rc = c;
            if (low_row(c) > br) br = low_row(c);
          end
          drp = m_right ? (px + rc * DX + SW + STEP_X > X_MAX) : (px + lc * DX - STEP_X < 0);
          if (drp) begin m_oy = py + DY; m_right = !m_right; end
          else m_ox = m_right ? px + STEP_X : px - STEP_X;
          step_q.push_back(m_ox * 4096 + m_oy);
          if (m_oy + br * DY + SH >= Y_LIMIT) m_st = 2;
        end else m_cnt++;
        if (m_srch) begin
          if (col_has(m_scol)) begin
            m_fv = 1; m_srch = 0;
            fire_q.push_back((px + m_scol * DX + SW / 2) * 4096 + py + low_row(m_scol) * DY + SH);
          end else begin
            m_sn++; m_scol = (m_scol + 1) % COLS;
            if (m_sn == COLS) m_srch = 0;
          end
        end else if (!pre_fv) begin
          if (m_fcnt >= FIRE - 1) begin
            m_fcnt = 0; m_lfsr = lfsr_step(m_lfsr); m_scol = m_lfsr % COLS; m_sn = 0; m_srch = 1;
          end else m_fcnt++;
        end
      end
      if (m_st != 0) begin
        if (m_fv) void'(fire_q.pop_back());
        m_fv = 0; m_srch = 0;
      end
    end
    if (kill_valid && int'(kill_idx) < N && m_alive[kill_idx]) begin
      m_alive[kill_idx] = 1'b0;
      if (m_alive == '0 && m_st == 0) wave_q.push_back(1);
    end
  endtask
  task automatic monitor();
    int e;
    if (reset || !started) return;
    if (step_pulse) begin
      check("step_pulse expected", int'(step_q.size() > 0), 1);
      if (step_q.size() > 0) begin
        e = step_q.pop_front();
        check("step origin_x", int'(origin_x), e / 4096);
        check("step origin_y", int'(origin_y), e % 4096);
      end
    end
    if (fire_valid && fire_ready) begin
      check("shot expected", int'(fire_q.size() > 0), 1);
      if (fire_q.size() > 0) begin
        e = fire_q.pop_front();
        check("fire_x", int'(fire_x), e / 4096);
        check("fire_y", int'(fire_y), e % 4096);
      end
    end
    if (wave_clear) begin
      check("wave_clear expected", int'(wave_q.size() > 0), 1);
      if (wave_q.size() > 0) void'(wave_q.pop_front());
    end
    check("fire_valid", int'(fire_valid), int'(m_fv));
    check("invaded", int'(invaded), int'(m_st == 2));
    check("alive_count", int'(alive_count), $countones(m_alive));
    check("alive", int'(alive), int'(m_alive));
  endtask
  initial forever begin @(posedge clk); model_tick(); end
  initial forever begin @(negedge clk); monitor(); end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    reset = 1; enable = 0; kill_valid = 0;
    repeat (2) cyc();
    reset = 0;
  endtask
  task automatic wait_step(output int n);
    n = 0;
    do begin cyc(); n++; end while (!step_pulse && n < 60);
  endtask
  task automatic kill(input int idx);
    kill_valid = 1; kill_idx = 5'(idx);
    cyc();
    kill_valid = 0;
  endtask
  task automatic random_run(input int cycles, input int kill_div);
    for (int i = 0; i < cycles; i++) begin
      enable = $urandom_range(0, 9) != 0;
      kill_valid = $urandom_range(0, kill_div - 1) == 0;
      kill_idx = 5'($urandom_range(0, 31));
      fire_ready = $urandom_range(0, 2) == 0;
      cyc();
    end
    kill_valid = 0;
  endtask
  initial begin
    int n, ev;
    cyc();
    started = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("reset origin_x", int'(origin_x), 150);
      check("reset origin_y", int'(origin_y), 40);
      check("reset alive", int'(alive), 'hFFFFFF);
      check("reset alive_count", int'(alive_count), 24);
      check("reset fire_valid", int'(fire_valid), 0);
    end
    enable = 1;
    wait_step(n);
    check("first step latency", n, 16);
    check("first march origin_x", int'(origin_x), 170);
    wait_step(n);
    check("first drop origin_x", int'(origin_x), 170);
    check("first drop origin_y", int'(origin_y), 90);
    random_run(1500, 20);
    do_reset();
    kill(7); kill(15); kill(23);
    check("kills with enable low", int'(alive_count), 21);
    kill(7); kill(30);
    check("ignored kills count", int'(alive_count), 21);
    check("ignored kills mask", int'(alive), 'h7F7F7F);
    enable = 1;
    wait_step(n);
    check("period after three kills", n, 13);
    for (int i = 22; i >= 0; i--) begin kill_valid = 1; kill_idx = 5'(i); cyc(); end
    kill_valid = 0;
    check("wave_clear on last kill", int'(wave_clear), 1);
    cyc();
    check("wave_clear single pulse", int'(wave_clear), 0);
    cyc();
    check("rearm alive", int'(alive), 'hFFFFFF);
    check("rearm alive_count", int'(alive_count), 24);
    check("rearm origin_x", int'(origin_x), 150);
    check("rearm origin_y", int'(origin_y), 40);
    random_run(1500, 6);
    do_reset();
    enable = 1; n = 0;
    while (!invaded && n < 3000) begin
      fire_ready = $urandom_range(0, 1) == 0;
      cyc();
      n++;
    end
    check("invasion reached", int'(invaded), 1);
    ev = 0;
    repeat (100) begin
      fire_ready = $urandom_range(0, 1) == 0;
      cyc();
      if (step_pulse || fire_valid) ev++;
    end
    check("activity after invasion", ev, 0);
    enable = 0;
    repeat (3) cyc();
    check("pending steps", step_q.size(), 0);
    check("pending waves", wave_q.size(), 0);
    check("pending shots", fire_q.size(), int'(m_fv));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
